// File: rtl/conv_pkg.sv
// Shared definitions for the conv row address generator.
// Holds the BRAM address width, dimension-counter width, physical
// buffer index encodings (0 = padding row), the sequencer FSM state
// encoding and a small helper that validates a run configuration.
package conv_pkg;

    localparam int ADR_W = 16;
    localparam int DIM_W = 16;

    localparam logic [1:0] IDX_PAD   = 2'd0;
    localparam logic [1:0] BUF_IDX_1 = 2'd1;
    localparam logic [1:0] BUF_IDX_2 = 2'd2;
    localparam logic [1:0] BUF_IDX_3 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A run is only meaningful when every loop bound is nonzero.
    function automatic logic dims_nonzero(input logic [DIM_W-1:0] h,
                                          input logic [DIM_W-1:0] w,
                                          input logic [DIM_W-1:0] t);
        return (h != {DIM_W{1'b0}}) && (w != {DIM_W{1'b0}}) &&
               (t != {DIM_W{1'b0}});
    endfunction

endpackage

// File: rtl/conv_row_adr_gen_if.sv
// Bus between the run controller, the conv row address generator and
// the conv BRAM handler.
//   master : the generator (takes control/config, drives requests)
//   slave  : the environment (drives control/config, takes requests)
// Control : en, start, img_rows, row_words, ch_tiles, base_adr
// Requests: row{1,2,3}_{buf,slab}_adr, row{1,2,3}_{buf,slab}_idx,
//           valid_row{1,2,3}_adr, last_row{1,2,3}_{buf,slab}_idx
// Status  : busy, done
interface conv_row_adr_gen_if;
    import conv_pkg::*;

    logic             en;
    logic             start;
    logic [DIM_W-1:0] img_rows;
    logic [DIM_W-1:0] row_words;
    logic [DIM_W-1:0] ch_tiles;
    logic [ADR_W-1:0] base_adr;

    logic [ADR_W-1:0] row1_buf_adr, row2_buf_adr, row3_buf_adr;
    logic [ADR_W-1:0] row1_slab_adr, row2_slab_adr, row3_slab_adr;
    logic [1:0]       row1_buf_idx, row2_buf_idx, row3_buf_idx;
    logic [1:0]       row1_slab_idx, row2_slab_idx, row3_slab_idx;
    logic             valid_row1_adr, valid_row2_adr, valid_row3_adr;
    logic [1:0]       last_row1_buf_idx, last_row2_buf_idx, last_row3_buf_idx;
    logic [1:0]       last_row1_slab_idx, last_row2_slab_idx, last_row3_slab_idx;
    logic             busy;
    logic             done;

    modport master (
        input  en, start, img_rows, row_words, ch_tiles, base_adr,
        output row1_buf_adr, row2_buf_adr, row3_buf_adr,
               row1_slab_adr, row2_slab_adr, row3_slab_adr,
               row1_buf_idx, row2_buf_idx, row3_buf_idx,
               row1_slab_idx, row2_slab_idx, row3_slab_idx,
               valid_row1_adr, valid_row2_adr, valid_row3_adr,
               last_row1_buf_idx, last_row2_buf_idx, last_row3_buf_idx,
               last_row1_slab_idx, last_row2_slab_idx, last_row3_slab_idx,
               busy, done
    );

    modport slave (
        output en, start, img_rows, row_words, ch_tiles, base_adr,
        input  row1_buf_adr, row2_buf_adr, row3_buf_adr,
               row1_slab_adr, row2_slab_adr, row3_slab_adr,
               row1_buf_idx, row2_buf_idx, row3_buf_idx,
               row1_slab_idx, row2_slab_idx, row3_slab_idx,
               valid_row1_adr, valid_row2_adr, valid_row3_adr,
               last_row1_buf_idx, last_row2_buf_idx, last_row3_buf_idx,
               last_row1_slab_idx, last_row2_slab_idx, last_row3_slab_idx,
               busy, done
    );

endinterface

// File: rtl/conv_row_slot_ctr.sv
// Mod-3 rotating row-slot counter. Tracks which physical buffer holds
// the current output row r and presents the buffer indices (1..3) of
// input rows r-1, r and r+1.
// Ports: clk, reset (sync, active-low), clear (back to row 0),
//        advance (move to next row), prev_idx / cur_idx / next_idx.
module conv_row_slot_ctr
    import conv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    output logic [1:0] prev_idx,
    output logic [1:0] cur_idx,
    output logic [1:0] next_idx
);

    logic [1:0] slot_r;

    // Slot of row r, i.e. r mod 3, kept incrementally instead of dividing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_r <= 2'd0;
        end else if (clear) begin
            slot_r <= 2'd0;
        end else if (advance) begin
            slot_r <= (slot_r == 2'd2) ? 2'd0 : slot_r + 2'd1;
        end
    end

    // Map slot to buffer indices of the three neighbouring rows.
    always_comb begin
        prev_idx = IDX_PAD;
        cur_idx  = IDX_PAD;
        next_idx = IDX_PAD;
        case (slot_r)
            2'd0: begin prev_idx = BUF_IDX_3; cur_idx = BUF_IDX_1; next_idx = BUF_IDX_2; end
            2'd1: begin prev_idx = BUF_IDX_1; cur_idx = BUF_IDX_2; next_idx = BUF_IDX_3; end
            2'd2: begin prev_idx = BUF_IDX_2; cur_idx = BUF_IDX_3; next_idx = BUF_IDX_1; end
            default: begin prev_idx = IDX_PAD; cur_idx = IDX_PAD; next_idx = IDX_PAD; end
        endcase
    end

endmodule

// File: rtl/conv_row_adr_gen.sv
// Conv row address generator: walks output rows of a 3x3 / stride-1 /
// pad-1 convolution (col innermost, then channel tile, then row) and
// issues one registered 3-row read request per beat to the BRAM handler.
// Ports: clk, reset (sync, active-low), bus (conv_row_adr_gen_if.master)
// carrying control/config inputs, request outputs and busy/done.
module conv_row_adr_gen
    import conv_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    conv_row_adr_gen_if.master         bus
);

    state_t           state_r, state_s;
    logic [DIM_W-1:0] h_r, w_r, t_r;
    logic [ADR_W-1:0] base_r;
    logic [DIM_W-1:0] col_r, tile_r, row_r;
    logic [ADR_W-1:0] tile_off_r;   // t * W, accumulated per tile

    logic             accept_s, beat_s;
    logic             last_col_s, last_tile_s, last_row_s;
    logic [1:0]       prev_idx_s, cur_idx_s, next_idx_s;

    logic [ADR_W-1:0] adr_r;
    logic [1:0]       idx1_r, idx2_r, idx3_r;
    logic [1:0]       last1_r, last2_r, last3_r;
    logic             valid1_r, valid2_r, valid3_r;
    logic             busy_r, done_r;

    assign accept_s    = (state_r == ST_IDLE) && bus.start;
    assign beat_s      = (state_r == ST_RUN) && bus.en;
    assign last_col_s  = (col_r  == w_r - 16'd1);
    assign last_tile_s = (tile_r == t_r - 16'd1);
    assign last_row_s  = (row_r  == h_r - 16'd1);

    conv_row_slot_ctr u_slot (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept_s),
        .advance  (beat_s && last_col_s && last_tile_s),
        .prev_idx (prev_idx_s),
        .cur_idx  (cur_idx_s),
        .next_idx (next_idx_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state: a zero-sized run goes straight to DONE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = dims_nonzero(bus.img_rows, bus.row_words, bus.ch_tiles)
                              ? ST_RUN : ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (beat_s && last_col_s && last_tile_s && last_row_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Config capture at start and col/tile/row loop counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            h_r        <= 16'd0;
            w_r        <= 16'd0;
            t_r        <= 16'd0;
            base_r     <= 16'd0;
            col_r      <= 16'd0;
            tile_r     <= 16'd0;
            row_r      <= 16'd0;
            tile_off_r <= 16'd0;
        end else if (accept_s) begin
            h_r        <= bus.img_rows;
            w_r        <= bus.row_words;
            t_r        <= bus.ch_tiles;
            base_r     <= bus.base_adr;
            col_r      <= 16'd0;
            tile_r     <= 16'd0;
            row_r      <= 16'd0;
            tile_off_r <= 16'd0;
        end else if (beat_s) begin
            if (!last_col_s) begin
                col_r <= col_r + 16'd1;
            end else begin
                col_r <= 16'd0;
                if (!last_tile_s) begin
                    tile_r     <= tile_r + 16'd1;
                    tile_off_r <= tile_off_r + w_r;
                end else begin
                    tile_r     <= 16'd0;
                    tile_off_r <= 16'd0;
                    row_r      <= row_r + 16'd1;
                end
            end
        end
    end

    // Registered request outputs; idx history follows every cycle so the
    // handler can steer data returning one cycle after the request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            adr_r    <= 16'd0;
            idx1_r   <= IDX_PAD;
            idx2_r   <= IDX_PAD;
            idx3_r   <= IDX_PAD;
            valid1_r <= 1'b0;
            valid2_r <= 1'b0;
            valid3_r <= 1'b0;
            last1_r  <= IDX_PAD;
            last2_r  <= IDX_PAD;
            last3_r  <= IDX_PAD;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            last1_r <= idx1_r;
            last2_r <= idx2_r;
            last3_r <= idx3_r;
            if (beat_s) begin
                adr_r    <= base_r + tile_off_r + col_r;
                idx1_r   <= (row_r == 16'd0) ? IDX_PAD : prev_idx_s;
                idx2_r   <= cur_idx_s;
                idx3_r   <= last_row_s ? IDX_PAD : next_idx_s;
                valid1_r <= (row_r != 16'd0);
                valid2_r <= 1'b1;
                valid3_r <= !last_row_s;
            end else begin
                valid1_r <= 1'b0;
                valid2_r <= 1'b0;
                valid3_r <= 1'b0;
            end
            busy_r <= (state_r == ST_RUN);
            done_r <= (state_r == ST_DONE);
        end
    end

    assign bus.row1_buf_adr       = adr_r;
    assign bus.row2_buf_adr       = adr_r;
    assign bus.row3_buf_adr       = adr_r;
    assign bus.row1_slab_adr      = adr_r;
    assign bus.row2_slab_adr      = adr_r;
    assign bus.row3_slab_adr      = adr_r;
    assign bus.row1_buf_idx       = idx1_r;
    assign bus.row2_buf_idx       = idx2_r;
    assign bus.row3_buf_idx       = idx3_r;
    assign bus.row1_slab_idx      = idx1_r;
    assign bus.row2_slab_idx      = idx2_r;
    assign bus.row3_slab_idx      = idx3_r;
    assign bus.valid_row1_adr     = valid1_r;
    assign bus.valid_row2_adr     = valid2_r;
    assign bus.valid_row3_adr     = valid3_r;
    assign bus.last_row1_buf_idx  = last1_r;
    assign bus.last_row2_buf_idx  = last2_r;
    assign bus.last_row3_buf_idx  = last3_r;
    assign bus.last_row1_slab_idx = last1_r;
    assign bus.last_row2_slab_idx = last2_r;
    assign bus.last_row3_slab_idx = last3_r;
    assign bus.busy               = busy_r;
    assign bus.done               = done_r;

endmodule

// File: tb/tb_conv_row_adr_gen.sv
// Directed testbench for conv_row_adr_gen with hand-computed expectations.
module tb_conv_row_adr_gen;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_row_adr_gen_if bus ();

    conv_row_adr_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int p1 = 0, p2 = 0, p3 = 0;   // row idx seen on the previous cycle

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input int adr,
                            input int i1, input int i2, input int i3,
                            input int v1, input int v2, input int v3);
        chk({tag, "_adr1"},  32'(bus.row1_buf_adr),  32'(adr));
        chk({tag, "_adr2"},  32'(bus.row2_buf_adr),  32'(adr));
        chk({tag, "_adr3"},  32'(bus.row3_buf_adr),  32'(adr));
        chk({tag, "_sadr2"}, 32'(bus.row2_slab_adr), 32'(adr));
        chk({tag, "_idx1"},  32'(bus.row1_buf_idx),  32'(i1));
        chk({tag, "_idx2"},  32'(bus.row2_buf_idx),  32'(i2));
        chk({tag, "_idx3"},  32'(bus.row3_buf_idx),  32'(i3));
        chk({tag, "_sidx1"}, 32'(bus.row1_slab_idx), 32'(i1));
        chk({tag, "_sidx3"}, 32'(bus.row3_slab_idx), 32'(i3));
        chk({tag, "_v1"},    32'(bus.valid_row1_adr), 32'(v1));
        chk({tag, "_v2"},    32'(bus.valid_row2_adr), 32'(v2));
        chk({tag, "_v3"},    32'(bus.valid_row3_adr), 32'(v3));
    endtask

    task automatic chk_last(input string tag);
        chk({tag, "_last1"},  32'(bus.last_row1_buf_idx),  32'(p1));
        chk({tag, "_last2"},  32'(bus.last_row2_buf_idx),  32'(p2));
        chk({tag, "_last3"},  32'(bus.last_row3_buf_idx),  32'(p3));
        chk({tag, "_slast2"}, 32'(bus.last_row2_slab_idx), 32'(p2));
    endtask

    task automatic set_cfg(input int h, input int w, input int t, input int base);
        bus.img_rows  = 16'(h);
        bus.row_words = 16'(w);
        bus.ch_tiles  = 16'(t);
        bus.base_adr  = 16'(base);
    endtask

    // Test 1 expectations: H=4, W=2, T=1
    int t1_r1 [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int t1_r2 [8] = '{1, 1, 2, 2, 3, 3, 1, 1};
    int t1_r3 [8] = '{2, 2, 3, 3, 1, 1, 0, 0};
    // Test 2 expectations: H=1, W=1, T=3, base=0xFFFF (wraps)
    int t2_adr [3] = '{16'hFFFF, 16'h0000, 16'h0001};
    // Test 3: en pattern around the edges after start
    bit t3_en [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        int eb, nvalid, e_adr, e1, e2, e3, row;

        reset = 1'b0;
        bus.en = 1'b0;
        bus.start = 1'b0;
        set_cfg(0, 0, 0, 0);
        tick();
        tick();
        // ---- reset state
        chk_beat("rst", 0, 0, 0, 0, 0, 0, 0);
        chk_last("rst");
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b1;
        tick();

        // ---- Test 1: H=4 W=2 T=1 base 0x100, second start in RUN ignored
        set_cfg(4, 2, 1, 16'h100);
        bus.en = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t1_busy_acc", 32'(bus.busy), 32'd0);
        for (int b = 0; b < 8; b++) begin
            if (b == 3) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            chk_beat($sformatf("t1_b%0d", b), 16'h100 + (b % 2),
                     t1_r1[b], t1_r2[b], t1_r3[b], (b >= 2) ? 1 : 0, 1, (b < 6) ? 1 : 0);
            chk_last($sformatf("t1_b%0d", b));
            chk($sformatf("t1_b%0d_busy", b), 32'(bus.busy), 32'd1);
            chk($sformatf("t1_b%0d_done", b), 32'(bus.done), 32'd0);
            p1 = t1_r1[b]; p2 = t1_r2[b]; p3 = t1_r3[b];
        end
        tick();
        chk("t1_done", 32'(bus.done), 32'd1);
        chk("t1_busy_end", 32'(bus.busy), 32'd0);
        chk("t1_v2_end", 32'(bus.valid_row2_adr), 32'd0);
        chk_last("t1_end");
        tick();
        chk("t1_done_pulse", 32'(bus.done), 32'd0);
        chk("t1_busy_idle", 32'(bus.busy), 32'd0);

        // ---- Test 2: H=1 W=1 T=3, address wrap at 2^16
        set_cfg(1, 1, 3, 16'hFFFF);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            tick();
            chk_beat($sformatf("t2_b%0d", b), t2_adr[b], 0, 1, 0, 0, 1, 0);
        end
        p1 = 0; p2 = 1; p3 = 0;
        tick();
        chk("t2_done", 32'(bus.done), 32'd1);
        chk_last("t2_end");
        tick();

        // ---- Test 3: H=2 W=3 T=1 base 0x10, en low for 2 cycles mid-row
        set_cfg(2, 3, 1, 16'h10);
        bus.en = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        eb = 0; nvalid = 0;
        e_adr = 16'hFFFF + 2; e1 = p1; e2 = p2; e3 = p3;  // held from test 2
        for (int i = 0; i < 8; i++) begin
            bus.en = t3_en[i];
            tick();
            if (t3_en[i]) begin
                row = eb / 3;
                e_adr = 16'h10 + (eb % 3);
                e1 = (row == 0) ? 0 : 1;
                e2 = row + 1;
                e3 = (row == 0) ? 2 : 0;
                eb++;
            end
            chk_beat($sformatf("t3_c%0d", i), e_adr & 16'hFFFF, e1, e2, e3,
                     (t3_en[i] && e1 != 0) ? 1 : 0, t3_en[i] ? 1 : 0,
                     (t3_en[i] && e3 != 0) ? 1 : 0);
            chk_last($sformatf("t3_c%0d", i));
            if (bus.valid_row2_adr) nvalid++;
            p1 = e1; p2 = e2; p3 = e3;
        end
        chk("t3_beats", 32'(nvalid), 32'd6);
        tick();
        chk("t3_done", 32'(bus.done), 32'd1);
        chk_last("t3_end");
        tick();

        // ---- Test 4: W=0 -> no beats, done two edges after start
        set_cfg(2, 0, 1, 16'h20);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t4_v2_a", 32'(bus.valid_row2_adr), 32'd0);
        chk("t4_busy_a", 32'(bus.busy), 32'd0);
        chk("t4_done_a", 32'(bus.done), 32'd0);
        tick();
        chk("t4_v2_b", 32'(bus.valid_row2_adr), 32'd0);
        chk("t4_busy_b", 32'(bus.busy), 32'd0);
        chk("t4_done_b", 32'(bus.done), 32'd1);
        tick();
        chk("t4_done_c", 32'(bus.done), 32'd0);

        // ---- Test 5: reset low at beat 3, then replay from r=0 c=0
        set_cfg(3, 2, 2, 16'h40);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            tick();
            chk($sformatf("t5_b%0d_adr", b), 32'(bus.row2_buf_adr), 32'(16'h40 + b));
            chk($sformatf("t5_b%0d_idx2", b), 32'(bus.row2_buf_idx), 32'd1);
        end
        reset = 1'b0;
        tick();
        chk_beat("t5_rst", 0, 0, 0, 0, 0, 0, 0);
        chk("t5_rst_last2", 32'(bus.last_row2_buf_idx), 32'd0);
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        chk("t5_rst_done", 32'(bus.done), 32'd0);
        reset = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk_beat("t5_replay0", 16'h40, 0, 1, 2, 0, 1, 1);
        chk("t5_replay_busy", 32'(bus.busy), 32'd1);
        tick();
        chk_beat("t5_replay1", 16'h41, 0, 1, 2, 0, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_row_adr_gen.md
# conv_row_adr_gen

Sequencer directly upstream of the conv BRAM handler: walks output rows of a 3x3, stride-1, pad-1 convolution and, per beat, issues the three input-row read requests (buffer/slab address, physical buffer index 1..3, valid) that the handler routes to the three row-buffer and slab BRAMs. It also produces the one-cycle-delayed `last_row*_idx` selects the handler needs to steer returning BRAM data. Index 0 marks a padding row, so the handler returns zero pixels for it.

## Interface
- `ADR_W`, 16, address width of buffer/slab BRAMs
- `clk`  input  1  clock
- `reset`  input  1  synchronous, active-low reset
- `en`  input  1  advance enable; low freezes counters
- `start`  input  1  one-cycle pulse, sampled only in IDLE
- `img_rows`  input  16  input/output image height H
- `row_words`  input  16  32-pixel words per row per channel tile W
- `ch_tiles`  input  16  channel tiles T
- `base_adr`  input  ADR_W  BRAM base address
- `row{1,2,3}_buf_adr`, `row{1,2,3}_slab_adr`  output  ADR_W  addresses for input rows r-1, r, r+1
- `row{1,2,3}_buf_idx`, `row{1,2,3}_slab_idx`  output  2  physical buffer 1..3; 0 = padding
- `valid_row{1,2,3}_adr`  output  1  request valid
- `last_row{1,2,3}_buf_idx`, `last_row{1,2,3}_slab_idx`  output  2  idx outputs delayed one cycle
- `busy`  output  1  high from accepted start until done
- `done`  output  1  one-cycle pulse after final beat

## Operation
- FSM: IDLE -> RUN on `start` when H, W, T all nonzero; `start` with any zero -> DONE directly. RUN -> DONE after the last beat. DONE -> IDLE unconditionally. `start` outside IDLE is ignored.
- Loop order: col c (0..W-1) innermost, then tile t (0..T-1), then row r (0..H-1). One beat per cycle while `en`=1 in RUN.
- Address, all three rows: `base_adr + t*W + c`, mod 2^ADR_W. Slab address equals buffer address; slab idx equals buffer idx.
- Input row i lives in buffer `(i mod 3)+1`. Row1 = r-1: idx 0, valid 0 when r=0. Row2 = r. Row3 = r+1: idx 0, valid 0 when r=H-1. With H=1, only row2 is valid.
- Row slot is kept as a mod-3 rotating counter advanced on row change, not computed by division.
- `en`=0 in RUN: counters hold; registered valids go 0 next cycle; addresses and idx hold.

## Timing
- All outputs are registered. Reset values: addresses 0, all idx 0, valids 0, `busy` 0, `done` 0, FSM IDLE.
- `start` sampled at edge k -> first beat on outputs after edge k+1. `busy` rises at edge k+1.
- `last_row*_idx` (edge n+1) = `row*_idx` (edge n), updated every cycle regardless of `en`. This matches the 1-cycle BRAM read latency.
- With `en` held high, H*W*T consecutive valid beats occur. `done` pulses the cycle after the last beat. `busy` falls with `done`.
- Reset low mid-RUN: every output takes its reset value at the next edge. No partial beat is issued.

## Structure
- Shared `conv_pkg`: `ADR_W`, `IDX_PAD = 2'd0`, buffer-index constants 1..3, and FSM state encoding.
- Sub-module `conv_row_slot_ctr`: mod-3 counter giving the slot of row r-1, r, r+1, with clear and advance inputs.

## Test plan
- H=4, W=2, T=1, base=0x100, `en`=1 -> 8 beats. Row-2 idx sequence 1,1,2,2,3,3,1,1. Addresses 0x100,0x101 repeating. Beats 0-1 row1 idx 0, valid 0. Beats 6-7 row3 idx 0, valid 0. `done` on cycle 10.
- H=1, W=1, T=3 -> 3 beats at base+0, base+1, base+2. Only row2 valid, idx 1. Row1 and row3 idx 0.
- Toggle `en` low for 2 cycles mid-row -> addresses hold, valids 0 for those beats. Sequence resumes with no skipped or duplicated column. Total valid beats = H*W*T.
- `last_row*_idx` check: every cycle it equals the previous cycle's `row*_idx`, including across `en` gaps.
- `start` with W=0 -> no valid beats. `done` 2 cycles after `start`, then IDLE. A second `start` pulse during RUN is ignored.
- `reset` low at beat 3 of a run -> next cycle all outputs 0 and FSM IDLE. A fresh `start` replays from r=0, c=0.
